// File: rtl/mul_div_seq.sv
// Sequential signed multiplier (radix-2 Booth) with an optional restoring divider.
// Define MULDIV_DIV_EN to build the divider; otherwise a divide request returns err.
module mul_div_seq (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] zhigh,
  output logic [31:0] zlow,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  state_t      state_next;
  logic [5:0]  count;
  logic [32:0] acc;
  logic [31:0] lsr;
  logic [31:0] mcand;
  logic        qm1;
  logic        exc;
  logic [32:0] mext;
  logic [32:0] booth_sum;
  logic [32:0] acc_step;
  logic [31:0] lsr_step;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

`ifdef MULDIV_DIV_EN
  logic        op_r;
  logic        neg_q;
  logic        neg_r;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] shifted;
  logic [32:0] trial;

  assign a_mag = a[31] ? -a : a;
  assign b_mag = b[31] ? -b : b;
  assign exc   = op && (b == 32'd0);
`else
  assign exc   = op;
`endif

  assign mext = {mcand[31], mcand};

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= IDLE;
    else        state <= state_next;
  end

  // Exceptional requests bypass RUN and report straight from DONE.
  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    done       = (state == DONE);
    case (state)
      IDLE:    if (start) state_next = exc ? DONE : RUN;
      RUN:     if (count == 6'd0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One iteration of either algorithm, plus the sign-corrected final result.
  always_comb begin
    booth_sum = acc;
    case ({lsr[0], qm1})
      2'b01:   booth_sum = acc + mext;
      2'b10:   booth_sum = acc - mext;
      default: booth_sum = acc;
    endcase
    acc_step = {booth_sum[32], booth_sum[32:1]};
    lsr_step = {booth_sum[0], lsr[31:1]};
    res_hi   = acc[31:0];
    res_lo   = lsr;
`ifdef MULDIV_DIV_EN
    shifted = {acc[31:0], lsr[31]};
    trial   = shifted - {1'b0, mcand};
    if (op_r) begin
      if (!trial[32]) begin
        acc_step = trial;
        lsr_step = {lsr[30:0], 1'b1};
      end else begin
        acc_step = shifted;
        lsr_step = {lsr[30:0], 1'b0};
      end
      res_lo = neg_q ? -lsr : lsr;
      res_hi = neg_r ? -acc[31:0] : acc[31:0];
    end
`endif
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      count <= 6'd0;
      acc   <= '0;
      lsr   <= '0;
      mcand <= '0;
      qm1   <= 1'b0;
      zhigh <= '0;
      zlow  <= '0;
      err   <= 1'b0;
`ifdef MULDIV_DIV_EN
      op_r  <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          err   <= 1'b0;
          count <= 6'd32;
          acc   <= '0;
          qm1   <= 1'b0;
          lsr   <= b;
          mcand <= a;
`ifdef MULDIV_DIV_EN
          op_r  <= op;
          neg_q <= a[31] ^ b[31];
          neg_r <= a[31];
          if (op) begin
            lsr   <= a_mag;
            mcand <= b_mag;
            if (b == 32'd0) begin
              zlow  <= '1;
              zhigh <= a;
              err   <= 1'b1;
              count <= 6'd0;
            end
          end
`else
          if (op) begin
            zlow  <= '0;
            zhigh <= '0;
            err   <= 1'b1;
            count <= 6'd0;
          end
`endif
        end
        RUN: begin
          if (count != 6'd0) begin
            acc   <= acc_step;
            lsr   <= lsr_step;
            qm1   <= lsr[0];
            count <= count - 6'd1;
          end else begin
            zhigh <= res_hi;
            zlow  <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_seq.sv
// Directed bench for mul_div_seq; divide expectations follow MULDIV_DIV_EN.
module tb_mul_div_seq;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic        op    = 1'b0;
  logic [31:0] a     = '0;
  logic [31:0] b     = '0;
  logic        busy;
  logic        done;
  logic [31:0] zhigh;
  logic [31:0] zlow;
  logic        err;

  int errors = 0;
  int checks = 0;

  mul_div_seq dut (
    .clock(clock), .clear(clear), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .zhigh(zhigh), .zlow(zlow), .err(err)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("[TB] check %s failed", tag);
    end
  endtask

  // Drive a one-cycle start pulse; it is sampled at the following rising edge.
  task automatic applyStimulus(input logic o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clock);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  // lat counts rising edges after the one that sampled start until done is seen.
  task automatic runOperation(input string tag, input logic o, input logic [31:0] x,
                              input logic [31:0] y, input int expLat, input logic [31:0] expHi,
                              input logic [31:0] expLo, input logic expErr, input int repulseAt);
    int edges = 0;
    applyStimulus(o, x, y);
    @(negedge clock);
    while (!done && edges < 100) begin
      @(negedge clock);
      edges++;
      if (edges == 1) checkOutput({tag, ".busy"}, {31'b0, busy}, 32'd1);
      if (repulseAt != 0 && edges == repulseAt) begin
        start = 1'b1; op = 1'b0; a = 32'd5; b = 32'd5;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    checkOutput({tag, ".timeout"}, {31'b0, done}, 32'd1);
    checkOutput({tag, ".lat"}, edges, expLat);
    checkOutput({tag, ".hi"}, zhigh, expHi);
    checkOutput({tag, ".lo"}, zlow, expLo);
    checkOutput({tag, ".err"}, {31'b0, err}, {31'b0, expErr});
    @(negedge clock);
    checkOutput({tag, ".donefall"}, {31'b0, done}, 32'd0);
    checkOutput({tag, ".idle"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #12;
    checkOutput("rst.busy", {31'b0, busy}, 32'd0);
    checkOutput("rst.done", {31'b0, done}, 32'd0);
    checkOutput("rst.err", {31'b0, err}, 32'd0);
    checkOutput("rst.hi", zhigh, 32'd0);
    checkOutput("rst.lo", zlow, 32'd0);
    @(negedge clock);
    clear = 1'b1;

    runOperation("mul7x-3", 1'b0, 32'd7, 32'hFFFFFFFD, 33, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 0);
    repeat (3) @(negedge clock);
    checkOutput("hold.hi", zhigh, 32'hFFFFFFFF);
    checkOutput("hold.lo", zlow, 32'hFFFFFFEB);
    runOperation("mulmin", 1'b0, 32'h80000000, 32'h80000000, 33, 32'h40000000, 32'h00000000, 1'b0, 0);
    runOperation("mulx16", 1'b0, 32'h12345678, 32'h00000010, 33, 32'h00000001, 32'h23456780, 1'b0, 0);
    runOperation("mulneg", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'h00000000, 32'h00000001, 1'b0, 0);

`ifdef MULDIV_DIV_EN
    runOperation("div-7/2", 1'b1, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 0);
    runOperation("div100/7", 1'b1, 32'd100, 32'd7, 33, 32'd2, 32'd14, 1'b0, 0);
    runOperation("divwrap", 1'b1, 32'h80000000, 32'hFFFFFFFF, 33, 32'd0, 32'h80000000, 1'b0, 0);
    runOperation("div0", 1'b1, 32'h1234, 32'd0, 0, 32'h1234, 32'hFFFFFFFF, 1'b1, 0);
`else
    runOperation("div-7/2", 1'b1, 32'hFFFFFFF9, 32'd2, 0, 32'd0, 32'd0, 1'b1, 0);
    runOperation("div0", 1'b1, 32'h1234, 32'd0, 0, 32'd0, 32'd0, 1'b1, 0);
`endif
    repeat (2) @(negedge clock);
    checkOutput("errhold", {31'b0, err}, 32'd1);

    runOperation("restart", 1'b0, 32'd7, 32'hFFFFFFFD, 33, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 10);

    applyStimulus(1'b0, 32'd7, 32'hFFFFFFFD);
    repeat (5) @(negedge clock);
    #2 clear = 1'b0;
    #1;
    checkOutput("midrst.busy", {31'b0, busy}, 32'd0);
    checkOutput("midrst.done", {31'b0, done}, 32'd0);
    checkOutput("midrst.err", {31'b0, err}, 32'd0);
    checkOutput("midrst.hi", zhigh, 32'd0);
    checkOutput("midrst.lo", zlow, 32'd0);
    @(negedge clock);
    clear = 1'b1;
    runOperation("mul3x5", 1'b0, 32'd3, 32'd5, 33, 32'd0, 32'd15, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
